keccak1024_pass_scheduler: RTL and testbench

//  Sequences the fully pipelined, stall-free KeccakF1600 core for a Keccak-1024 hash of 1024-bit messages (r=576, c=1024).

---
 rtl/keccak1024_pass_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_keccak1024_pass_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak1024_pass_scheduler.sv
// ---------------------------------------------------------------------------
// keccak1024_pass_scheduler
//
// Schedules the two KeccakF1600 passes of a Keccak-1024 hash (r=576,
// c=1024) of a 1024-bit message through a fully pipelined, stall-free core
// of depth LAT. Pass 1 absorbs message lanes 0..8 from the input port.
// Pass 2 recirculates the core output, XORed with lanes 9..15 and the
// padding. Those lanes wait in an in-order tail FIFO.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      message present on in_msg / in_tag
//   in_ready      message accepted when in_valid & in_ready at posedge
//   in_msg        1024-bit message, lane i = [64*i+:64]
//   in_tag        opaque per-message tag
//   perm_in       state driven into the core (combinational)
//   perm_out      state returned by the core, LAT cycles after perm_in
//   out_valid     one-cycle pulse, out_state/out_tag hold a finished hash
//   out_state     final state after pass 2
//   out_tag       tag of the finished message
//   inflight      number of messages currently inside the core
// ---------------------------------------------------------------------------
module keccak1024_pass_scheduler #(
    parameter int LAT   = 47,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1023:0]    in_msg,
    input  logic [TAG_W-1:0] in_tag,
    output logic [1599:0]    perm_in,
    input  logic [1599:0]    perm_out,
    output logic             out_valid,
    output logic [1599:0]    out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic [5:0]       inflight
);

    typedef enum logic [1:0] {
        INJ_IDLE,
        INJ_ACCEPT,
        INJ_RECIRC
    } inj_e;

    localparam logic [5:0] LAT_CNT = 6'(LAT);

    // Slot tracker: entry k describes the core stage that perm_out will show
    // LAT-1-k cycles from now, so index LAT-1 describes perm_out itself.
    logic [LAT-1:0]   r_vld;
    logic [LAT-1:0]   r_pass;
    logic [TAG_W-1:0] r_tag [LAT];

    // Tail store for message lanes 9..15
    logic [447:0]     r_fifo_mem [LAT];
    logic [5:0]       r_wr_ptr;
    logic [5:0]       r_rd_ptr;
    logic [5:0]       r_fifo_cnt;

    logic [5:0]       r_inflight;
    logic             r_out_valid;
    logic [1599:0]    r_out_state;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_tail_vld;
    logic             w_tail_pass;
    logic [TAG_W-1:0] w_tail_tag;
    logic             w_recirc;
    logic             w_retire;
    logic             w_accept;
    inj_e             w_inj;
    logic             w_slot_vld;
    logic             w_slot_pass;
    logic [TAG_W-1:0] w_slot_tag;
    logic [447:0]     w_fifo_head;

    function automatic logic [5:0] ptr_inc(input logic [5:0] p);
        return (p == LAT_CNT - 6'd1) ? 6'd0 : p + 6'd1;
    endfunction

    assign w_tail_vld  = r_vld[LAT-1];
    assign w_tail_pass = r_pass[LAT-1];
    assign w_tail_tag  = r_tag[LAT-1];
    assign w_fifo_head = r_fifo_mem[r_rd_ptr];

    // Recirculation owns the slot whenever a pass-1 result is at the tail;
    // in_ready therefore never looks at in_valid.
    assign w_recirc = w_tail_vld & ~w_tail_pass;
    assign w_retire = w_tail_vld & w_tail_pass;
    assign w_accept = ~w_recirc & in_valid;
    assign in_ready = ~w_recirc;

    always_comb begin
        w_inj       = INJ_IDLE;
        w_slot_vld  = 1'b0;
        w_slot_pass = 1'b0;
        w_slot_tag  = in_tag;
        perm_in     = '0;
        if (w_recirc) begin
            w_inj       = INJ_RECIRC;
            w_slot_vld  = 1'b1;
            w_slot_pass = 1'b1;
            w_slot_tag  = w_tail_tag;
            // Block 2: lanes 9..15 of the message, pad 0x01 in lane 7 and
            // the final-bit 0x80.. in lane 8 (last lane of the 576-bit rate).
            perm_in     = perm_out ^ {1024'd0, 64'h8000_0000_0000_0000,
                                      64'h0000_0000_0000_0001, w_fifo_head};
        end else if (in_valid) begin
            w_inj       = INJ_ACCEPT;
            w_slot_vld  = 1'b1;
            perm_in     = {1024'd0, in_msg[575:0]};
        end
    end

    // Slot tracker, control half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LAT-2:0], w_slot_vld};
        end
    end

    // Slot tracker, data half: qualified by r_vld, so left unreset
    always_ff @(posedge clk) begin
        r_pass   <= {r_pass[LAT-2:0], w_slot_pass};
        r_tag[0] <= w_slot_tag;
        for (int i = 1; i < LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
        end
    end

    // Tail FIFO storage
    always_ff @(posedge clk) begin
        if (w_inj == INJ_ACCEPT) begin
            r_fifo_mem[r_wr_ptr] <= in_msg[1023:576];
        end
    end

    // Tail FIFO pointers and occupancy; accept and recirc are exclusive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr   <= ptr_inc(r_wr_ptr);
                r_fifo_cnt <= r_fifo_cnt + 6'd1;
            end else if (w_recirc) begin
                r_rd_ptr   <= ptr_inc(r_rd_ptr);
                r_fifo_cnt <= r_fifo_cnt - 6'd1;
            end
        end
    end

    // In-flight count and retire register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= '0;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_tag   <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   if (r_inflight != LAT_CNT) r_inflight <= r_inflight + 6'd1;
                2'b01:   if (r_inflight != 6'd0)    r_inflight <= r_inflight - 6'd1;
                default: r_inflight <= r_inflight;
            endcase
            r_out_valid <= w_retire;
            if (w_retire) begin
                r_out_state <= perm_out;
                r_out_tag   <= w_tail_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign out_tag   = r_out_tag;
    assign inflight  = r_inflight;

    a_fifo_overflow:  assert property (@(posedge clk) disable iff (rst)
                          !(w_accept && (r_fifo_cnt == LAT_CNT)));
    a_fifo_underflow: assert property (@(posedge clk) disable iff (rst)
                          !(w_recirc && (r_fifo_cnt == 6'd0)));

endmodule

// File: tb/tb_keccak1024_pass_scheduler.sv
module tb_keccak1024_pass_scheduler;

    localparam int LAT   = 47;
    localparam int TAG_W = 8;
    localparam logic [1599:0] KC = {25{64'h9E37_79B9_7F4A_7C15}};

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1023:0]    in_msg;
    logic [TAG_W-1:0] in_tag;
    logic [1599:0]    perm_in;
    logic [1599:0]    perm_out;
    logic             out_valid;
    logic [1599:0]    out_state;
    logic [TAG_W-1:0] out_tag;
    logic [5:0]       inflight;

    keccak1024_pass_scheduler #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_msg(in_msg), .in_tag(in_tag), .perm_in(perm_in), .perm_out(perm_out),
        .out_valid(out_valid), .out_state(out_state), .out_tag(out_tag),
        .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in permutation core: LAT-deep pipeline of a simple bijection
    function automatic logic [1599:0] core_f(input logic [1599:0] x);
        return {x[1598:0], x[1599]} ^ KC;
    endfunction

    logic [1599:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= core_f(perm_in);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign perm_out = core_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1599:0] blk1(input logic [1023:0] m);
        return {1024'd0, m[575:0]};
    endfunction

    function automatic logic [1599:0] blk2(input logic [1023:0] m);
        return {1024'd0, 64'h8000_0000_0000_0000, 64'h1, m[1023:576]};
    endfunction

    function automatic logic [1599:0] model(input logic [1023:0] m);
        return core_f(core_f(blk1(m)) ^ blk2(m));
    endfunction

    function automatic logic [1023:0] mk_msg(input int k);
        logic [1023:0] m;
        for (int i = 0; i < 16; i++) m[64*i +: 64] = {32'(k), 32'(i)} ^ 64'hC3A5_5A3C_0F1E_2D4B;
        return m;
    endfunction

    typedef struct {
        logic [1599:0]    st;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    typedef struct {
        logic [1023:0]    msg;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] exp_tag;
        int               exp_lat;
    } vec_t;

    exp_t exp_q [$];
    vec_t vecs [4];
    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    int last_lat = 0;
    logic [TAG_W-1:0] last_tag = '0;
    int msg_k = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_state(input string nm, input logic [1599:0] act, input logic [1599:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < 25; i++) begin
                if (act[64*i +: 64] !== exp[64*i +: 64]) begin
                    $display("FAIL %s: lane %0d got %h, expected %h (cycle %0d)",
                             nm, i, act[64*i +: 64], exp[64*i +: 64], cyc);
                    break;
                end
            end
        end
    endtask

    // Scoreboard step, run once per cycle at the falling edge
    task automatic sb();
        exp_t e;
        chk("inflight_le_lat", 64'(inflight <= 6'(LAT)), 64'd1);
        if (in_valid && in_ready) begin
            e.st  = model(in_msg);
            e.tag = in_tag;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        if (out_valid) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_out: out_valid with tag %h, expected no result", out_tag);
            end else begin
                e = exp_q.pop_front();
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk_state("out_state", out_state, e.st);
                chk("latency", 64'(cyc - e.acc), 64'(2*LAT+1));
                last_tag = out_tag;
                last_lat = cyc - e.acc;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (!rst) sb();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            next();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3*LAT && exp_q.size() != 0; i++) begin
            sample();
            next();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        sample();
        chk("drain_inflight", 64'(inflight), 64'd0);
        next();
    endtask

    task automatic run_single(input vec_t v);
        int start;
        bit got;
        in_valid = 1'b1; in_msg = v.msg; in_tag = v.tag;
        sample();
        chk("single_ready", 64'(in_ready), 64'd1);
        chk_state("accept_perm_in", perm_in, blk1(v.msg));
        start = n_out;
        next();
        in_valid = 1'b0;
        run(LAT-1);
        sample();
        chk("recirc_ready", 64'(in_ready), 64'd0);
        chk_state("recirc_perm_in", perm_in, core_f(blk1(v.msg)) ^ blk2(v.msg));
        next();
        got = 1'b0;
        for (int i = 0; i < 2*LAT; i++) begin
            sample();
            if (n_out != start) begin
                got = 1'b1;
                break;
            end
            next();
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL single_timeout: no out_valid, expected tag %h", v.exp_tag);
        end else begin
            chk("single_tag", 64'(last_tag), 64'(v.exp_tag));
            chk("single_lat", 64'(last_lat), 64'(v.exp_lat));
            next();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{msg: '0, tag: 8'h5A, exp_tag: 8'h5A, exp_lat: 2*LAT+1};
        vecs[1] = '{msg: {1024{1'b1}}, tag: 8'hA5, exp_tag: 8'hA5, exp_lat: 2*LAT+1};
        vecs[2] = '{msg: mk_msg(7), tag: 8'h01, exp_tag: 8'h01, exp_lat: 2*LAT+1};
        vecs[3] = '{msg: {512{2'b10}}, tag: 8'hFF, exp_tag: 8'hFF, exp_lat: 2*LAT+1};

        rst = 1'b1; in_valid = 1'b0; in_msg = '0; in_tag = '0;
        next();
        sample();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk_state("rst_out_state", out_state, '0);
        chk_state("rst_perm_in", perm_in, '0);
        next();
        rst = 1'b0;
        sample();
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        chk_state("idle_perm_in", perm_in, '0);
        next();

        // Single messages from the vector table
        for (int v = 0; v < 4; v++) run_single(vecs[v]);
        drain();

        // Stream: in_valid held 200 cycles; slots come back in blocks of LAT
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'b1; in_msg = mk_msg(msg_k); in_tag = TAG_W'(msg_k);
            sample();
            chk("stream_ready", 64'(in_ready), 64'(((k / LAT) % 2) == 0));
            if (in_ready) msg_k++;
            next();
        end
        in_valid = 1'b0;
        drain();

        // Saturation from empty: LAT accepts, then blocked until first retire
        for (int k = 0; k <= 2*LAT; k++) begin
            in_valid = 1'b1; in_msg = mk_msg(msg_k); in_tag = TAG_W'(msg_k);
            sample();
            chk("sat_ready", 64'(in_ready), 64'((k < LAT) || (k == 2*LAT)));
            if (k == LAT) chk("sat_inflight_full", 64'(inflight), 64'(LAT));
            if (in_ready) msg_k++;
            next();
        end
        in_valid = 1'b0;
        drain();

        // Retire and accept in the same cycle
        in_valid = 1'b1; in_msg = mk_msg(500); in_tag = 8'h33;
        sample();
        next();
        in_valid = 1'b0;
        run(2*LAT-1);
        in_valid = 1'b1; in_msg = mk_msg(501); in_tag = 8'h34;
        sample();
        chk("coll_ready", 64'(in_ready), 64'd1);
        chk("coll_inflight_before", 64'(inflight), 64'd1);
        next();
        in_valid = 1'b0;
        sample();
        chk("coll_out_valid", 64'(out_valid), 64'd1);
        chk("coll_out_tag", 64'(out_tag), 64'h33);
        chk("coll_inflight_after", 64'(inflight), 64'd1);
        next();
        drain();

        // Reset mid-flight
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_msg = mk_msg(600 + k); in_tag = TAG_W'(8'h80 + k);
            sample();
            next();
        end
        in_valid = 1'b0;
        run(20);
        sample();
        chk("pre_rst_inflight", 64'(inflight), 64'd10);
        next();
        rst = 1'b1;
        sample();
        chk("midrst_inflight", 64'(inflight), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        next();
        next();
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3*LAT; k++) begin
            sample();
            chk("after_rst_quiet", 64'(out_valid), 64'd0);
            next();
        end
        run_single(vecs[0]);
        drain();

        // Random idle gaps at about 30% offer density
        for (int k = 0; k < 300; k++) begin
            in_valid = ($urandom_range(0, 99) < 30);
            in_msg = mk_msg(1000 + k); in_tag = TAG_W'(k);
            run(1);
        end
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
